// File: rtl/fmap4_col_feeder_if.sv
// Bundle of the pixel-load handshake and the 4-map column stream of fmap4_col_feeder.
// The block is the slave; whoever loads pixels and consumes columns uses the master view.
interface fmap4_col_feeder_if #(
  parameter int BIT_WIDTH = 8
);
  logic signed [BIT_WIDTH-1:0] pix_in;
  logic                        pix_valid;
  logic                        pix_ready;
  logic                        hold;
  logic signed [BIT_WIDTH-1:0] out01, out02, out03, out04, out05;
  logic signed [BIT_WIDTH-1:0] out11, out12, out13, out14, out15;
  logic signed [BIT_WIDTH-1:0] out21, out22, out23, out24, out25;
  logic signed [BIT_WIDTH-1:0] out31, out32, out33, out34, out35;
  logic                        en;
  logic                        window_valid;
  logic                        row_last;
  logic                        done;

  modport master (
    output pix_in, pix_valid, hold,
    input  pix_ready,
    input  out01, out02, out03, out04, out05,
    input  out11, out12, out13, out14, out15,
    input  out21, out22, out23, out24, out25,
    input  out31, out32, out33, out34, out35,
    input  en, window_valid, row_last, done
  );

  modport slave (
    input  pix_in, pix_valid, hold,
    output pix_ready,
    output out01, out02, out03, out04, out05,
    output out11, out12, out13, out14, out15,
    output out21, out22, out23, out24, out25,
    output out31, out32, out33, out34, out35,
    output en, window_valid, row_last, done
  );
endinterface

// File: rtl/fmap4_col_feeder.sv
// Buffers four IN_DIM x IN_DIM feature maps, then streams 5-row columns of all
// four maps in lockstep to the 4-channel 5x5 convolution unit.
module fmap4_col_feeder #(
  parameter int BIT_WIDTH = 8,
  parameter int IN_DIM    = 14,
  parameter int KSIZE     = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  fmap4_col_feeder_if.slave     bus,
  output logic [1:0]            dbg_state
);
  localparam int NPIX = 4 * IN_DIM * IN_DIM;
  localparam int LCW  = $clog2(NPIX);
  localparam int RCW  = $clog2(IN_DIM);

  localparam logic [1:0] S_LOAD   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]                  state;
  logic [LCW-1:0]              load_cnt;
  logic [RCW-1:0]              r;
  logic [RCW-1:0]              c;
  logic signed [BIT_WIDTH-1:0] mem   [NPIX];
  logic signed [BIT_WIDTH-1:0] col_d [4][KSIZE];
  logic signed [BIT_WIDTH-1:0] col_q [4][KSIZE];
  logic                        en_q, wv_q, rl_q, done_q;
  logic                        xfer;

  // Handshake: a pixel moves on any rising edge where pix_valid && pix_ready;
  // pix_ready is high only while loading, and stays low during the done pulse.
  assign bus.pix_ready = (state == S_LOAD) && !done_q;
  assign xfer          = bus.pix_valid && bus.pix_ready;
  assign dbg_state     = state;

  // Buffer layout is map-major then row-major, matching the load order.
  always_comb begin
    for (int x = 0; x < 4; x++) begin
      for (int k = 0; k < KSIZE; k++) begin
        col_d[x][k] = mem[LCW'(x * IN_DIM * IN_DIM + k * IN_DIM)
                          + LCW'(r) * LCW'(IN_DIM) + LCW'(c)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && xfer) mem[load_cnt] <= bus.pix_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_LOAD;
      load_cnt <= '0;
      r        <= '0;
      c        <= '0;
      en_q     <= 1'b0;
      wv_q     <= 1'b0;
      rl_q     <= 1'b0;
      done_q   <= 1'b0;
      for (int x = 0; x < 4; x++) begin
        for (int k = 0; k < KSIZE; k++) col_q[x][k] <= '0;
      end
    end else begin
      en_q   <= 1'b0;
      wv_q   <= 1'b0;
      rl_q   <= 1'b0;
      done_q <= 1'b0;
      case (state)
        S_LOAD: begin
          if (xfer) begin
            if (load_cnt == LCW'(NPIX - 1)) begin
              state    <= S_STREAM;
              load_cnt <= '0;
              r        <= '0;
              c        <= '0;
            end else begin
              load_cnt <= load_cnt + 1'b1;
            end
          end
        end
        S_STREAM: begin
          // A stalled cycle leaves the column registers and position untouched.
          if (!bus.hold) begin
            col_q <= col_d;
            en_q  <= 1'b1;
            wv_q  <= (c >= RCW'(KSIZE - 1));
            rl_q  <= (c == RCW'(IN_DIM - 1));
            if (c == RCW'(IN_DIM - 1)) begin
              c <= '0;
              if (r == RCW'(IN_DIM - KSIZE)) begin
                r     <= '0;
                state <= S_DONE;
              end else begin
                r <= r + 1'b1;
              end
            end else begin
              c <= c + 1'b1;
            end
          end
        end
        S_DONE: begin
          done_q <= 1'b1;
          state  <= S_LOAD;
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  assign bus.en           = en_q;
  assign bus.window_valid = wv_q;
  assign bus.row_last     = rl_q;
  assign bus.done         = done_q;

  assign bus.out01 = col_q[0][0];
  assign bus.out02 = col_q[0][1];
  assign bus.out03 = col_q[0][2];
  assign bus.out04 = col_q[0][3];
  assign bus.out05 = col_q[0][4];
  assign bus.out11 = col_q[1][0];
  assign bus.out12 = col_q[1][1];
  assign bus.out13 = col_q[1][2];
  assign bus.out14 = col_q[1][3];
  assign bus.out15 = col_q[1][4];
  assign bus.out21 = col_q[2][0];
  assign bus.out22 = col_q[2][1];
  assign bus.out23 = col_q[2][2];
  assign bus.out24 = col_q[2][3];
  assign bus.out25 = col_q[2][4];
  assign bus.out31 = col_q[3][0];
  assign bus.out32 = col_q[3][1];
  assign bus.out33 = col_q[3][2];
  assign bus.out34 = col_q[3][3];
  assign bus.out35 = col_q[3][4];
endmodule

// File: doc/fmap4_col_feeder.md
Name: fmap4_col_feeder

Overview:
- Producer side of the 4-map 5x5 convolution datapath. Buffers four IN_DIM x IN_DIM feature maps received as a pixel stream, then streams 5-row vertical columns of all four maps in lockstep.
- Each output column drives the four 5-input column ports and the latch enable of the 4-channel conv unit.
- Sits between the pooling/feature-map store and the C3-style convolution stage.

Parameters:
- BIT_WIDTH, 8, signed pixel width.
- IN_DIM, 14, feature-map height/width. Must be >= 5.
- KSIZE, 5, window height. Fixed to 5. Other values unsupported.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous reset, active-low (asserted when 0 at a clk edge).
- pix_in  input  BIT_WIDTH signed  load pixel. Order: map-major (m0..m3), then row-major.
- pix_valid  input  1  pix_in valid.
- pix_ready  output  1  block accepts a pixel this cycle. Transfer occurs when pix_valid && pix_ready.
- hold  input  1  downstream stall. 1 freezes the stream.
- out01..out05  output  BIT_WIDTH signed each  map 0, rows r..r+4, column c.
- out11..out15  output  BIT_WIDTH signed each  map 1, same rows/column.
- out21..out25  output  BIT_WIDTH signed each  map 2, same rows/column.
- out31..out35  output  BIT_WIDTH signed each  map 3, same rows/column.
- en  output  1  column on out* is new this cycle. Downstream latches on it.
- window_valid  output  1  with en: c >= KSIZE-1, so a full 5x5 window is complete.
- row_last  output  1  with en: c == IN_DIM-1.
- done  output  1  one-cycle pulse after the final column of the pass.

Behaviour:
- Storage: internal array of 4*IN_DIM*IN_DIM pixels. Combinational read, registered outputs.
- FSM states: LOAD, STREAM, DONE.
- Reset (rst==0 at edge):
  - state=LOAD; load counter, r and c = 0.
  - All out* = 0; en, window_valid, row_last, done = 0.
  - Buffer contents are don't-care.
  - Reset mid-LOAD or mid-STREAM aborts the pass. No done pulse.
- LOAD:
  - pix_ready=1.
  - Each transfer writes buffer[load_cnt] and increments load_cnt. Cycles with pix_valid=0 do nothing.
  - When the transfer with load_cnt==4*IN_DIM*IN_DIM-1 completes: state->STREAM, r=c=0, load_cnt=0.
- STREAM:
  - pix_ready=0.
  - Each cycle with hold=0:
    - Register column (r,c) into out*: outXk = map X, row r+k-1, column c.
    - en=1, window_valid=(c>=4), row_last=(c==IN_DIM-1).
    - Advance: c++. At c==IN_DIM-1: c=0, r++.
  - Latency: column selected in cycle t appears on out* with en=1 in cycle t+1.
  - Each cycle with hold=1: en=window_valid=row_last=0, out* hold their previous value, r and c frozen.
  - hold only affects STREAM.
  - After emitting r==IN_DIM-5, c==IN_DIM-1: state->DONE.
- DONE: done=1 for exactly one cycle, en=0, then state->LOAD with pix_ready=1 the following cycle.
- Totals per pass:
  - (IN_DIM-4)*IN_DIM en pulses. Default 140.
  - (IN_DIM-4)^2 window_valid pulses. Default 100.
  - IN_DIM-4 row_last pulses.
- Widths: load counter ceil(log2(4*IN_DIM^2)); r, c ceil(log2(IN_DIM)). No arithmetic on pixel values; sign passes through unchanged.
- pix_valid during STREAM/DONE is ignored (pix_ready=0). The upstream holds it.

Test Plan:
- Reset then ramp load: pixel at map m, row r, col c = (m*196+r*14+c) mod 128.
  - Required: pix_ready drops on the cycle after the 784th transfer.
  - First en column: out01=0, out02=14, out03=28, out04=42, out05=56, out11=68, out21=8, out31=76; window_valid=0.
- Full pass, hold=0:
  - 140 consecutive en cycles, 100 window_valid, 10 row_last.
  - Column r=9, c=13: out05 = (13*14+13) mod 128 = 67.
  - done pulses once, the cycle after the last en. pix_ready=1 the cycle after done.
- Load with pix_valid toggling every other cycle:
  - Contents identical to the continuous load.
  - Stream starts after exactly 784 accepted pixels.
- hold asserted for 3 cycles at r=2, c=6:
  - en=0 for those 3 cycles; out* unchanged.
  - The next en column is r=2, c=7. Total en still 140.
- rst=0 held one cycle during STREAM at r=5:
  - All outputs 0 the next cycle, no done, pix_ready=1.
  - A new full load then yields a correct pass.
- Negative pixels (value -128 at m3, r4, c0): out35 = -128 (0x80) on the first column. Sign preserved.
